kmu_cta_dispatcher: RTL and testbench

//  Parametrised KMU-to-core CTA dispatcher: takes one kernel launch (grid dims, warps, PC, param) and walks the grid x-fastest.

---
 rtl/kmu_cta_dispatcher.sv | 159 +++++++++++++++
 tb/tb_kmu_cta_dispatcher.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kmu_cta_dispatcher.sv
// kmu_cta_dispatcher: walks a launched grid x-fastest and deals CTAs round-robin to cores under per-core credits
module kmu_cta_dispatcher #(
    parameter int NUM_CORES         = 4,
    parameter int XLEN              = 32,
    parameter int CTA_W             = 16,
    parameter int MAX_CTAS_PER_CORE = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     launch_valid,
    output logic                     launch_ready,
    input  logic [31:0]              launch_num_warps,
    input  logic [XLEN-1:0]          launch_start_pc,
    input  logic [XLEN-1:0]          launch_param,
    input  logic [CTA_W-1:0]         launch_grid_x,
    input  logic [CTA_W-1:0]         launch_grid_y,
    input  logic [CTA_W-1:0]         launch_grid_z,
    output logic [NUM_CORES-1:0]     task_valid,
    input  logic [NUM_CORES-1:0]     task_ready,
    output logic [160+2*XLEN-1:0]    task_data,
    input  logic [NUM_CORES-1:0]     core_done,
    output logic                     busy,
    output logic                     kernel_done,
    output logic                     err_spurious
);
    localparam int TW = 3 * CTA_W;
    localparam int DW = 160 + 2 * XLEN;
    localparam int CW = $clog2(MAX_CTAS_PER_CORE + 1);
    localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;

    typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, DONE} state_t;

    state_t               state;
    logic [31:0]          num_warps;
    logic [XLEN-1:0]      start_pc;
    logic [XLEN-1:0]      param;
    logic [CTA_W-1:0]     gx, gy, gz;
    logic [CTA_W-1:0]     cx, cy, cz;
    logic [31:0]          cid;
    logic [TW-1:0]        total, issued, retired;
    logic [CW-1:0]        credit   [NUM_CORES];
    logic [CW-1:0]        cred_nxt [NUM_CORES];
    logic [PW-1:0]        rr_ptr, rr_nxt, idx;
    logic [NUM_CORES-1:0] hs_vec, dec, sel_oh;
    logic [TW-1:0]        ndone;
    logic                 hs, last, x_last, y_last, dim_zero;
    logic [CTA_W-1:0]     nx, ny, nz;

    function automatic logic [DW-1:0] pack(input logic [31:0] w, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] p,
                                           input logic [CTA_W-1:0] x, input logic [CTA_W-1:0] y,
                                           input logic [CTA_W-1:0] z, input logic [31:0] id);
        return {w, pc, p, 32'(x), 32'(y), 32'(z), id};
    endfunction

    assign launch_ready = state == IDLE;
    assign busy         = state != IDLE;
    assign hs           = |hs_vec;
    assign last         = issued + TW'(1) == total;
    assign x_last       = cx == gx - CTA_W'(1);
    assign y_last       = cy == gy - CTA_W'(1);
    assign nx           = x_last ? '0 : cx + CTA_W'(1);
    assign ny           = x_last ? (y_last ? '0 : cy + CTA_W'(1)) : cy;
    assign nz           = x_last && y_last ? cz + CTA_W'(1) : cz;
    assign dim_zero     = launch_grid_x == '0 || launch_grid_y == '0 || launch_grid_z == '0;

    // Eligibility uses post-update credits so a core filled by this cycle's handshake is skipped.
    always_comb begin
        int j;
        hs_vec = task_valid & task_ready;
        rr_nxt = rr_ptr;
        ndone  = '0;
        sel_oh = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            dec[i]      = core_done[i] && credit[i] != '0;
            cred_nxt[i] = credit[i] + CW'(hs_vec[i]) - CW'(dec[i]);
            ndone       = ndone + TW'(dec[i]);
            if (hs_vec[i]) rr_nxt = i == NUM_CORES - 1 ? '0 : PW'(i + 1);
        end
        for (int k = 0; k < NUM_CORES; k++) begin
            j   = int'(rr_nxt) + k;
            idx = PW'(j >= NUM_CORES ? j - NUM_CORES : j);
            if (sel_oh == '0 && int'(cred_nxt[idx]) < MAX_CTAS_PER_CORE) sel_oh[idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            task_valid   <= '0;
            task_data    <= '0;
            kernel_done  <= 1'b0;
            err_spurious <= 1'b0;
            num_warps    <= '0;
            start_pc     <= '0;
            param        <= '0;
            gx           <= '0;
            gy           <= '0;
            gz           <= '0;
            cx           <= '0;
            cy           <= '0;
            cz           <= '0;
            cid          <= '0;
            total        <= '0;
            issued       <= '0;
            retired      <= '0;
            credit       <= '{default: '0};
            rr_ptr       <= '0;
        end else begin
            credit       <= cred_nxt;
            rr_ptr       <= rr_nxt;
            retired      <= retired + ndone;
            err_spurious <= err_spurious | |(core_done & ~dec);
            kernel_done  <= state == DONE;
            case (state)
                IDLE: if (launch_valid) begin
                    num_warps <= launch_num_warps;
                    start_pc  <= launch_start_pc;
                    param     <= launch_param;
                    gx        <= launch_grid_x;
                    gy        <= launch_grid_y;
                    gz        <= launch_grid_z;
                    total     <= TW'(launch_grid_x) * TW'(launch_grid_y) * TW'(launch_grid_z);
                    issued    <= '0;
                    retired   <= '0;
                    cx        <= '0;
                    cy        <= '0;
                    cz        <= '0;
                    cid       <= '0;
                    if (dim_zero) state <= DONE;
                    else begin
                        state      <= DISPATCH;
                        task_valid <= sel_oh;
                        task_data  <= pack(launch_num_warps, launch_start_pc, launch_param, '0, '0, '0, '0);
                    end
                end
                DISPATCH: if (hs) begin
                    issued <= issued + TW'(1);
                    cx     <= nx;
                    cy     <= ny;
                    cz     <= nz;
                    cid    <= cid + 32'd1;
                    if (last) begin
                        task_valid <= '0;
                        state      <= DRAIN;
                    end else begin
                        task_valid <= sel_oh;
                        task_data  <= pack(num_warps, start_pc, param, nx, ny, nz, cid + 32'd1);
                    end
                end else if (task_valid == '0) begin
                    task_valid <= sel_oh;
                    task_data  <= pack(num_warps, start_pc, param, cx, cy, cz, cid);
                end
                DRAIN: if (retired == total) state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kmu_cta_dispatcher.sv
// tb_kmu_cta_dispatcher: directed vectors and corner-case sequences for the CTA dispatcher
module tb_kmu_cta_dispatcher;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         launch_valid = 1'b0;
    logic         launch_ready;
    logic [31:0]  launch_num_warps = '0;
    logic [31:0]  launch_start_pc = '0;
    logic [31:0]  launch_param = '0;
    logic [15:0]  launch_grid_x = '0, launch_grid_y = '0, launch_grid_z = '0;
    logic [3:0]   task_valid;
    logic [3:0]   task_ready = '0;
    logic [223:0] task_data;
    logic [3:0]   core_done = '0;
    logic         busy, kernel_done, err_spurious;

    int n_tests = 0;
    int n_fail  = 0;

    kmu_cta_dispatcher dut (
        .clk(clk), .reset_n(reset_n), .launch_valid(launch_valid), .launch_ready(launch_ready),
        .launch_num_warps(launch_num_warps), .launch_start_pc(launch_start_pc), .launch_param(launch_param),
        .launch_grid_x(launch_grid_x), .launch_grid_y(launch_grid_y), .launch_grid_z(launch_grid_z),
        .task_valid(task_valid), .task_ready(task_ready), .task_data(task_data), .core_done(core_done),
        .busy(busy), .kernel_done(kernel_done), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] gx, gy, gz;
        logic [31:0] warps, pc, param;
        int          ncta;
    } vec_t;

    vec_t tab[7];

    task automatic chk(input string name, input logic [223:0] act, input logic [223:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [223:0] exp_data(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] p,
                                              input int x, input int y, input int z, input int id);
        return {w, pc, p, 16'h0, 16'(x), 16'h0, 16'(y), 16'h0, 16'(z), 32'(id)};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic do_launch(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                             input logic [31:0] w, input logic [31:0] pc, input logic [31:0] p);
        launch_grid_x    = x;
        launch_grid_y    = y;
        launch_grid_z    = z;
        launch_num_warps = w;
        launch_start_pc  = pc;
        launch_param     = p;
        launch_valid     = 1'b1;
        chk("launch_ready", 224'(launch_ready), 224'(1));
        step();
        launch_valid = 1'b0;
    endtask

    task automatic wait_kd(input string name, input int max);
        logic seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            step();
            seen = kernel_done;
        end
        chk(name, 224'(seen), 224'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int rr, x, y, z;
        int cnt[4];
        logic [3:0] mask;
        tab[0] = '{16'd2, 16'd1, 16'd1, 32'd4,  32'h0000_1000, 32'h0000_00a0, 2};
        tab[1] = '{16'd3, 16'd2, 16'd1, 32'd8,  32'h0000_2000, 32'h0000_00b0, 6};
        tab[2] = '{16'd1, 16'd1, 16'd1, 32'd1,  32'h8000_0004, 32'hdead_beef, 1};
        tab[3] = '{16'd2, 16'd2, 16'd2, 32'd16, 32'h0000_3000, 32'h0000_0c00, 8};
        tab[4] = '{16'd1, 16'd0, 16'd1, 32'd2,  32'h0000_4000, 32'h0000_0d00, 0};
        tab[5] = '{16'd0, 16'd3, 16'd3, 32'd2,  32'h0000_5000, 32'h0000_0e00, 0};
        tab[6] = '{16'd4, 16'd1, 16'd2, 32'd3,  32'hffff_fffc, 32'h1234_5678, 8};

        step();
        chk("rst_task_valid", 224'(task_valid), 224'(0));
        chk("rst_task_data", task_data, 224'(0));
        chk("rst_kernel_done", 224'(kernel_done), 224'(0));
        chk("rst_err", 224'(err_spurious), 224'(0));
        chk("rst_busy", 224'(busy), 224'(0));
        chk("rst_launch_ready", 224'(launch_ready), 224'(1));
        reset_n = 1'b1;
        step();

        rr = 0;
        task_ready = 4'b1111;
        for (int v = 0; v < 7; v++) begin
            do_launch(tab[v].gx, tab[v].gy, tab[v].gz, tab[v].warps, tab[v].pc, tab[v].param);
            x = 0; y = 0; z = 0;
            cnt = '{default: 0};
            for (int n = 0; n < tab[v].ncta; n++) begin
                chk($sformatf("v%0d_tv%0d", v, n), 224'(task_valid), 224'(4'b1 << ((rr + n) % 4)));
                chk($sformatf("v%0d_data%0d", v, n), task_data,
                    exp_data(tab[v].warps, tab[v].pc, tab[v].param, x, y, z, n));
                cnt[(rr + n) % 4]++;
                x++;
                if (x == int'(tab[v].gx)) begin
                    x = 0;
                    y++;
                    if (y == int'(tab[v].gy)) begin
                        y = 0;
                        z++;
                    end
                end
                step();
            end
            chk($sformatf("v%0d_tv_end", v), 224'(task_valid), 224'(0));
            chk($sformatf("v%0d_busy", v), 224'(busy), 224'(1));
            if (tab[v].ncta == 0) begin
                chk($sformatf("v%0d_kd_early", v), 224'(kernel_done), 224'(0));
                step();
                chk($sformatf("v%0d_kd", v), 224'(kernel_done), 224'(1));
            end else begin
                for (int r = 0; r < 2; r++) begin
                    for (int c = 0; c < 4; c++) mask[c] = cnt[c] > r;
                    if (mask != 4'b0) begin
                        core_done = mask;
                        step();
                        core_done = 4'b0;
                    end
                end
                chk($sformatf("v%0d_kd_0", v), 224'(kernel_done), 224'(0));
                step();
                chk($sformatf("v%0d_kd_1", v), 224'(kernel_done), 224'(0));
                step();
                chk($sformatf("v%0d_kd", v), 224'(kernel_done), 224'(1));
            end
            step();
            chk($sformatf("v%0d_kd_pulse", v), 224'(kernel_done), 224'(0));
            chk($sformatf("v%0d_idle", v), 224'(launch_ready), 224'(1));
            chk($sformatf("v%0d_err", v), 224'(err_spurious), 224'(0));
            rr = (rr + tab[v].ncta) % 4;
        end

        // back-pressure: offer to core0 must hold target and data
        do_reset();
        task_ready = 4'b1110;
        do_launch(16'd3, 16'd1, 16'd1, 32'd5, 32'h0000_6000, 32'h0000_0f00);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_tv%0d", i), 224'(task_valid), 224'(4'b0001));
            chk($sformatf("stall_data%0d", i), task_data, exp_data(32'd5, 32'h6000, 32'h0f00, 0, 0, 0, 0));
            step();
        end
        task_ready = 4'b1111;
        step();
        chk("stall_tv_c1", 224'(task_valid), 224'(4'b0010));
        chk("stall_data_c1", task_data, exp_data(32'd5, 32'h6000, 32'h0f00, 1, 0, 0, 1));
        step();
        chk("stall_tv_c2", 224'(task_valid), 224'(4'b0100));
        chk("stall_data_c2", task_data, exp_data(32'd5, 32'h6000, 32'h0f00, 2, 0, 0, 2));
        step();
        chk("stall_tv_end", 224'(task_valid), 224'(0));
        core_done = 4'b0111;
        step();
        core_done = 4'b0;
        wait_kd("stall_kd", 6);

        // credit exhaustion and round-robin restart
        do_reset();
        task_ready = 4'b1111;
        do_launch(16'd10, 16'd1, 16'd1, 32'd2, 32'h0000_7000, 32'h0000_0100);
        for (int n = 0; n < 8; n++) begin
            chk($sformatf("cred_tv%0d", n), 224'(task_valid), 224'(4'b1 << (n % 4)));
            chk($sformatf("cred_data%0d", n), task_data, exp_data(32'd2, 32'h7000, 32'h0100, n, 0, 0, n));
            step();
        end
        chk("cred_full0", 224'(task_valid), 224'(0));
        step();
        chk("cred_full1", 224'(task_valid), 224'(0));
        core_done = 4'b0001;
        step();
        core_done = 4'b0;
        chk("cred_tv8", 224'(task_valid), 224'(4'b0001));
        chk("cred_data8", task_data, exp_data(32'd2, 32'h7000, 32'h0100, 8, 0, 0, 8));
        core_done = 4'b0100;
        step();
        core_done = 4'b0;
        chk("cred_tv9", 224'(task_valid), 224'(4'b0100));
        chk("cred_data9", task_data, exp_data(32'd2, 32'h7000, 32'h0100, 9, 0, 0, 9));
        step();
        chk("cred_tv_end", 224'(task_valid), 224'(0));
        core_done = 4'b1111;
        step();
        step();
        core_done = 4'b0;
        wait_kd("cred_kd", 6);
        chk("err_before", 224'(err_spurious), 224'(0));
        core_done = 4'b0100;
        step();
        core_done = 4'b0;
        chk("err_spurious", 224'(err_spurious), 224'(1));
        step();
        chk("err_sticky", 224'(err_spurious), 224'(1));

        // reset in the middle of dispatch, then a clean 1x1x1 kernel
        do_reset();
        do_launch(16'd8, 16'd1, 16'd1, 32'd1, 32'h0000_8000, 32'h0000_0200);
        step();
        step();
        step();
        chk("mid_tv", 224'(task_valid), 224'(4'b1000));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tv", 224'(task_valid), 224'(0));
        chk("mid_rst_data", task_data, 224'(0));
        chk("mid_rst_busy", 224'(busy), 224'(0));
        chk("mid_rst_ready", 224'(launch_ready), 224'(1));
        chk("mid_rst_kd", 224'(kernel_done), 224'(0));
        chk("mid_rst_err", 224'(err_spurious), 224'(0));
        step();
        reset_n = 1'b1;
        do_launch(16'd1, 16'd1, 16'd1, 32'd9, 32'h0000_9000, 32'h0000_0300);
        chk("post_tv", 224'(task_valid), 224'(4'b0001));
        chk("post_data", task_data, exp_data(32'd9, 32'h9000, 32'h0300, 0, 0, 0, 0));
        step();
        chk("post_tv_end", 224'(task_valid), 224'(0));
        core_done = 4'b0001;
        step();
        core_done = 4'b0;
        wait_kd("post_kd", 5);
        chk("post_err", 224'(err_spurious), 224'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
